// File: rtl/lmsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lmsm_sequencer
// Brief    : Expands an LM/SM register mask into one load/store micro-op per set bit.
// Revision : 1.0
// ============================================================================
module lmsm_sequencer #(
   parameter int DATA_W = 16,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_sm,
   input  logic [MASK_W-1:0] mask,
   input  logic [DATA_W-1:0] base,
   input  logic              hold,
   input  logic              flush,
   output logic              busy,
   output logic              stall_fetch,
   output logic              uop_valid,
   output logic              uop_store,
   output logic [2:0]        uop_reg,
   output logic [DATA_W-1:0] uop_addr,
   output logic              uop_last,
   output logic              done
);

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_run  = 1'b1;

   logic [0:0]        r_state;
   logic [MASK_W-1:0] r_mask;
   logic [DATA_W-1:0] r_addr;
   logic              r_is_sm;
   logic              r_done;

   logic              w_run;
   logic [2:0]        w_reg;
   logic [MASK_W-1:0] w_mask_rest;
   logic              w_last;

   assign w_run = (r_state == c_run);

   // Scanning downward leaves the lowest set bit as the final winner.
   always_comb begin
      w_reg = 3'd0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (r_mask[i]) begin
            w_reg = 3'(i);
         end
      end
   end

   assign w_mask_rest = r_mask & (r_mask - MASK_W'(1));
   assign w_last      = w_run && (r_mask != '0) && (w_mask_rest == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
         r_mask  <= '0;
         r_addr  <= '0;
         r_is_sm <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= c_idle;
            r_mask  <= '0;
         end else if (r_state == c_idle) begin
            if (start) begin
               if (mask != '0) begin
                  r_state <= c_run;
                  r_mask  <= mask;
                  r_addr  <= base;
                  r_is_sm <= is_sm;
               end else begin
                  r_done <= 1'b1;
               end
            end
         end else if (!hold) begin
            r_mask <= w_mask_rest;
            r_addr <= r_addr + DATA_W'(1);
            if (w_last) begin
               r_state <= c_idle;
               r_done  <= 1'b1;
            end
         end
      end
   end

   // Micro-op fields are gated so the bus reads all-zero whenever idle.
   assign busy        = w_run;
   assign uop_valid   = w_run;
   assign uop_store   = w_run && r_is_sm;
   assign uop_reg     = w_run ? w_reg : 3'd0;
   assign uop_addr    = w_run ? r_addr : '0;
   assign uop_last    = w_last;
   assign done        = r_done;
   assign stall_fetch = ((r_state == c_idle) && start && (mask != '0) && !flush)
                     || (w_run && !(w_last && !hold));

endmodule
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmsm_sequencer
// Brief    : Scoreboard bench for lmsm_sequencer with a mask-list reference model.
// Revision : 1.0
// ============================================================================
module tb_lmsm_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_sm;
   logic [7:0]  mask;
   logic [15:0] base;
   logic        hold;
   logic        flush;
   logic        busy;
   logic        stall_fetch;
   logic        uop_valid;
   logic        uop_store;
   logic [2:0]  uop_reg;
   logic [15:0] uop_addr;
   logic        uop_last;
   logic        done;

   lmsm_sequencer #(.DATA_W(16), .MASK_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_sm(is_sm), .mask(mask),
      .base(base), .hold(hold), .flush(flush), .busy(busy),
      .stall_fetch(stall_fetch), .uop_valid(uop_valid), .uop_store(uop_store),
      .uop_reg(uop_reg), .uop_addr(uop_addr), .uop_last(uop_last), .done(done)
   );

   typedef struct packed {
      logic [2:0]  rg;
      logic [15:0] addr;
      logic        store;
      logic        last;
   } uop_t;

   typedef struct packed {
      logic busy;
      logic stall;
      logic done;
   } ctl_t;

   uop_t uop_q[$];
   ctl_t ctl_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 0;
   bit   pend_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle control flags, plus one uop popped per presented micro-op.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (ctl_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ctl_underflow act=empty exp=entry t=%0t", $time);
         end else begin
            ctl_t c;
            c = ctl_q.pop_front();
            chk("busy", 32'(busy), 32'(c.busy));
            chk("uop_valid", 32'(uop_valid), 32'(c.busy));
            chk("stall_fetch", 32'(stall_fetch), 32'(c.stall));
            chk("done", 32'(done), 32'(c.done));
         end
         if (uop_valid) begin
            if (uop_q.size() == 0) begin
               total++; bad++;
               $display("FAIL uop_underflow act=valid exp=none t=%0t", $time);
            end else begin
               uop_t u;
               u = uop_q.pop_front();
               chk("uop_reg", 32'(uop_reg), 32'(u.rg));
               chk("uop_addr", 32'(uop_addr), 32'(u.addr));
               chk("uop_store", 32'(uop_store), 32'(u.store));
               chk("uop_last", 32'(uop_last), 32'(u.last));
            end
         end
      end
   end

   task automatic step(input bit b, input bit s, input bit next_done);
      ctl_q.push_back('{busy: b, stall: s, done: pend_done});
      pend_done = next_done;
      @(posedge clk);
      #1;
   endtask

   // flush_at: -1 none, -2 flush alongside start, else RUN-cycle index to flush on.
   task automatic run_instr(input bit sm, input logic [7:0] m, input logic [15:0] b,
                            input int flush_at, input int hold_pct, input logic [31:0] hold_pat);
      int regs[$];
      int k;
      int rc;
      bit hv;
      bit lst;
      start = 1'b1; is_sm = sm; mask = m; base = b;
      hold  = 1'($urandom);
      flush = (flush_at == -2);
      if (flush_at == -2) begin
         step(1'b0, 1'b0, 1'b0);
      end else begin
         step(1'b0, m != 8'h00, m == 8'h00);
      end
      if (m != 8'h00 && flush_at != -2) begin
         for (int bi = 0; bi < 8; bi++) if (m[bi]) regs.push_back(bi);
         k = 0;
         rc = 0;
         forever begin
            start = 1'($urandom); is_sm = 1'($urandom);
            mask  = 8'($urandom); base  = 16'($urandom);
            hv = ((rc < 32) && hold_pat[rc]) || (int'($urandom_range(0, 99)) < hold_pct);
            hold  = hv;
            flush = (rc == flush_at);
            lst = (k == regs.size() - 1);
            uop_q.push_back('{rg: 3'(regs[k]), addr: 16'(b + 16'(k)), store: sm, last: lst});
            step(1'b1, !(lst && !hv), lst && !hv && !flush);
            if (rc == flush_at) break;
            if (!hv) begin
               if (lst) break;
               k++;
            end
            rc++;
         end
      end
      start = 1'b0; flush = 1'b0;
      repeat (int'($urandom_range(1, 2))) begin
         hold = 1'($urandom);
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; is_sm = 1'b0; mask = 8'h00;
      base = 16'h0000; hold = 1'b0; flush = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stall", 32'(stall_fetch), 0);
      chk("rst_valid", 32'(uop_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_addr", 32'(uop_addr), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      run_instr(1'b0, 8'h25, 16'h0100, -1, 0, 32'h0);
      run_instr(1'b1, 8'h81, 16'hFFFF, -1, 0, 32'h0);
      run_instr(1'b0, 8'h00, 16'h1234, -1, 0, 32'h0);
      run_instr(1'b1, 8'h03, 16'h0040, -1, 0, 32'h3);
      run_instr(1'b0, 8'hFF, 16'h2000, 2, 0, 32'h0);
      run_instr(1'b1, 8'h40, 16'h0010, 0, 0, 32'h0);
      run_instr(1'b0, 8'h18, 16'h0300, -2, 0, 32'h0);

      for (int n = 0; n < 60; n++) begin
         logic [7:0]  m;
         logic [15:0] b;
         int          fa;
         m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
         fa = -1;
         if ($urandom_range(0, 5) == 0) fa = int'($urandom_range(0, 6));
         else if ($urandom_range(0, 11) == 0) fa = -2;
         run_instr(1'($urandom), m, b, fa, 30, 32'h0);
      end

      // Asynchronous reset in the middle of an SM instruction.
      mon_en = 1'b0;
      start = 1'b1; is_sm = 1'b1; mask = 8'h0F; base = 16'h1234; hold = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", 32'(uop_valid), 1);
      chk("pre_rst_reg", 32'(uop_reg), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_stall", 32'(stall_fetch), 0);
      chk("arst_valid", 32'(uop_valid), 0);
      chk("arst_store", 32'(uop_store), 0);
      chk("arst_last", 32'(uop_last), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_reg", 32'(uop_reg), 0);
      chk("arst_addr", 32'(uop_addr), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      pend_done = 1'b0;
      mon_en = 1'b1;
      run_instr(1'b0, 8'h10, 16'h0500, -1, 0, 32'h0);
      run_instr(1'b1, 8'hA6, 16'hFFFE, -1, 40, 32'h0);

      mon_en = 1'b0;
      chk("uop_q_empty", 32'(uop_q.size()), 0);
      chk("ctl_q_empty", 32'(ctl_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
